// File: rtl/counter_input_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_input_ctrl_if
//  Purpose  : Bundles the raw pushbutton/switch inputs and the counter-control
//             outputs of counter_input_ctrl into one interface.
//  Signals  : btn_load  raw load pushbutton (1 = pressed)
//             btn_dir   raw direction pushbutton (1 = pressed)
//             sw[3:0]   raw slide switches carrying the load value
//             LD        one-cycle load pulse to the downstream counter
//             up_dn     count direction (0 = up, 1 = down)
//             D[3:0]    load value to the downstream counter
//  Modports : master - board/stimulus side (drives buttons, reads outputs)
//             slave  - controller side
//  Revision : 1.0 - initial release
// ============================================================================
interface counter_input_ctrl_if;
  logic       btn_load;
  logic       btn_dir;
  logic [3:0] sw;
  logic       LD;
  logic       up_dn;
  logic [3:0] D;

  modport master (
    output btn_load, btn_dir, sw,
    input  LD, up_dn, D
  );

  modport slave (
    input  btn_load, btn_dir, sw,
    output LD, up_dn, D
  );
endinterface
`default_nettype wire

// File: rtl/counter_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_input_ctrl
//  Purpose  : Conditions bouncy pushbuttons and switches into clean control
//             for an up/down counter: two-flop synchronizers on every raw
//             input, one debouncer per button, a one-cycle LD pulse per
//             debounced load press with D capturing the switches, and the
//             count direction on up_dn.
//  Ports    : clk    - system clock, rising edge
//             reset  - asynchronous, active-high reset
//             bus    - counter_input_ctrl_if.slave (btn_load, btn_dir, sw in;
//                      LD, up_dn, D out)
//  Params   : DEBOUNCE_CYCLES - stable cycles needed to accept a button
//             level change (2..65535)
//  Config   : DIR_TOGGLE_EN defined   -> up_dn toggles on each debounced
//                                        btn_dir press
//             DIR_TOGGLE_EN undefined -> up_dn follows the debounced btn_dir
//                                        level, one cycle later
//  Revision : 1.0 - initial release
// ============================================================================
module counter_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  counter_input_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // The counter never holds DEBOUNCE_CYCLES itself: the edge that would
  // reach it flips db and clears instead.
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Raw bit layout: [5] btn_dir, [4] btn_load, [3:0] sw
  logic [5:0] w_raw;
  logic [5:0] r_meta;
  logic [5:0] r_sync;
  logic [1:0] w_db;        // [0] load, [1] dir

  assign w_raw = {bus.btn_dir, bus.btn_load, bus.sw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
      logic [CNT_W-1:0] r_cnt;
      logic             r_db;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
          r_db  <= 1'b0;
        end else if (r_sync[4+gi] == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
          r_db  <= ~r_db;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_db[gi] = r_db;
    end
  endgenerate

  // Load path: rising edge of the debounced level gives exactly one pulse
  // per press; release and hold produce nothing.
  logic       r_load_q;
  logic       w_load_rise;
  logic       r_ld;
  logic [3:0] r_d;

  assign w_load_rise = w_db[0] & ~r_load_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_q <= 1'b0;
      r_ld     <= 1'b0;
      r_d      <= '0;
    end else begin
      r_load_q <= w_db[0];
      r_ld     <= w_load_rise;
      if (w_load_rise) begin
        r_d <= r_sync[3:0];
      end
    end
  end

  // Direction path, independent of the load path.
  logic r_up_dn;

`ifdef DIR_TOGGLE_EN
  logic r_dir_q;
  logic w_dir_rise;

  assign w_dir_rise = w_db[1] & ~r_dir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dir_q <= 1'b0;
      r_up_dn <= 1'b0;
    end else begin
      r_dir_q <= w_db[1];
      if (w_dir_rise) begin
        r_up_dn <= ~r_up_dn;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_up_dn <= 1'b0;
    end else begin
      r_up_dn <= w_db[1];
    end
  end
`endif

  assign bus.LD    = r_ld;
  assign bus.D     = r_d;
  assign bus.up_dn = r_up_dn;

endmodule
`default_nettype wire
